// File: rtl/spi_ram_burst.sv
// Parametrised single-port RAM driven by 2-bit-opcode SPI command words.
// Supports address auto-increment bursts and flags out-of-range or unloaded-pointer commands on err.
module spi_ram_burst #(
    parameter int WIDTH     = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH+1:0] din,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] dout,
    output logic             tx_valid,
    output logic             err
);

    localparam int             AW       = $clog2(MEM_DEPTH);
    localparam logic [WIDTH:0] LP_DEPTH = (WIDTH+1)'(MEM_DEPTH);
    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MEM_DEPTH - 1);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [WIDTH-1:0] r_wr_addr;
    logic [WIDTH-1:0] r_rd_addr;
    logic             r_rd_loaded;

    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_payload;
    logic             w_wr_in_range;
    logic             w_rd_in_range;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_reject;

    assign w_op          = din[WIDTH+1:WIDTH];
    assign w_payload     = din[WIDTH-1:0];
    assign w_wr_in_range = ({1'b0, r_wr_addr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, r_rd_addr} < LP_DEPTH);
    assign w_wr_ok       = rx_valid && (w_op == OP_WR_DATA) && w_wr_in_range;
    assign w_rd_ok       = rx_valid && (w_op == OP_RD_DATA) && r_rd_loaded && w_rd_in_range;
    assign w_reject      = rx_valid &&
                           (((w_op == OP_WR_DATA) && !w_wr_in_range) ||
                            ((w_op == OP_RD_DATA) && !(r_rd_loaded && w_rd_in_range)));

    // Wrap at the last real word, not at 2**WIDTH, so odd depths burst cleanly.
    function automatic logic [WIDTH-1:0] f_next_addr(input logic [WIDTH-1:0] a);
        if (AUTO_INC == 0) begin
            return a;
        end
        return (a == LP_LAST) ? '0 : a + WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_addr[AW-1:0]] <= w_payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout        <= '0;
            tx_valid    <= 1'b0;
            err         <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_rd_loaded <= 1'b0;
        end else begin
            tx_valid <= w_rd_ok;
            err      <= w_reject;
            if (rx_valid && (w_op == OP_WR_ADDR)) begin
                r_wr_addr <= w_payload;
            end
            if (w_wr_ok) begin
                r_wr_addr <= f_next_addr(r_wr_addr);
            end
            if (rx_valid && (w_op == OP_RD_ADDR)) begin
                r_rd_addr   <= w_payload;
                r_rd_loaded <= 1'b1;
            end
            if (w_rd_ok) begin
                dout      <= r_mem[r_rd_addr[AW-1:0]];
                r_rd_addr <= f_next_addr(r_rd_addr);
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: three instances (256/auto-inc, 200/auto-inc, 256/no-inc)
// checked against an array-based reference model plus directed expected values.
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din_a  [3];
    logic       rxv_a  [3];
    logic [7:0] dout_a [3];
    logic       tx_a   [3];
    logic       err_a  [3];

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [7:0] m_mem  [3][256];
    int         m_wr   [3];
    int         m_rd   [3];
    bit         m_ld   [3];
    logic [7:0] m_dout [3];
    bit         e_tx   [3];
    bit         e_err  [3];

    always #5 clk = ~clk;

    spi_ram_burst #(.WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_dut0 (
        .clk(clk), .rst(rst), .din(din_a[0]), .rx_valid(rxv_a[0]),
        .dout(dout_a[0]), .tx_valid(tx_a[0]), .err(err_a[0]));
    spi_ram_burst #(.WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din_a[1]), .rx_valid(rxv_a[1]),
        .dout(dout_a[1]), .tx_valid(tx_a[1]), .err(err_a[1]));
    spi_ram_burst #(.WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_dut2 (
        .clk(clk), .rst(rst), .din(din_a[2]), .rx_valid(rxv_a[2]),
        .dout(dout_a[2]), .tx_valid(tx_a[2]), .err(err_a[2]));

    function automatic int dep(int k);
        return (k == 1) ? 200 : 256;
    endfunction

    function automatic bit ainc(int k);
        return (k != 2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_wr[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
            m_dout[k] = 8'h00; e_tx[k] = 0; e_err[k] = 0;
        end
    endtask

    task automatic model_cmd(int k, bit [1:0] op, bit [7:0] pay);
        case (op)
            2'b00: m_wr[k] = pay;
            2'b01: begin
                if (m_wr[k] < dep(k)) begin
                    m_mem[k][m_wr[k]] = pay;
                    if (ainc(k)) m_wr[k] = (m_wr[k] + 1) % dep(k);
                end else begin
                    e_err[k] = 1;
                end
            end
            2'b10: begin m_rd[k] = pay; m_ld[k] = 1; end
            default: begin
                if (m_ld[k] && m_rd[k] < dep(k)) begin
                    m_dout[k] = m_mem[k][m_rd[k]];
                    e_tx[k] = 1;
                    if (ainc(k)) m_rd[k] = (m_rd[k] + 1) % dep(k);
                end else begin
                    e_err[k] = 1;
                end
            end
        endcase
    endtask

    task automatic send(int k, bit [1:0] op, bit [7:0] pay);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            rxv_a[j] = 1'b0; e_tx[j] = 0; e_err[j] = 0;
        end
        din_a[k] = {op, pay};
        rxv_a[k] = 1'b1;
        model_cmd(k, op, pay);
        @(posedge clk);
        #1;
        rxv_a[k] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                rxv_a[j] = 1'b0; din_a[j] = 10'($urandom); e_tx[j] = 0; e_err[j] = 0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (dout_a[k] !== 8'h00 || tx_a[k] !== 1'b0 || err_a[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state k=%0d dout=%h tx=%b err=%b required 00/0/0",
                         k, dout_a[k], tx_a[k], err_a[k]);
            end
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 3; k++) begin
            if (ainc(k)) send(k, 2'b00, 8'h00);
            for (int a = 0; a < dep(k); a++) begin
                if (!ainc(k)) send(k, 2'b00, 8'(a));
                send(k, 2'b01, 8'($urandom));
                tests++;
                if (err_a[k] !== 1'b0 || tx_a[k] !== 1'b0) begin
                    fails++;
                    $display("FAIL fill k=%0d addr=%0d err=%b tx=%b required 0/0",
                             k, a, err_a[k], tx_a[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        send(0, 2'b10, 8'h10);
        send(0, 2'b11, 8'h00);
        tests++;
        if (tx_a[0] !== 1'b1 || dout_a[0] !== m_mem[0][16]) begin
            fails++;
            $display("FAIL pre_reset_read tx=%b dout=%h required 1/%h", tx_a[0], dout_a[0], m_mem[0][16]);
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (dout_a[k] !== 8'h00 || tx_a[k] !== 1'b0 || err_a[k] !== 1'b0) begin
                fails++;
                $display("FAIL async_reset k=%0d dout=%h tx=%b err=%b required 00/0/0",
                         k, dout_a[k], tx_a[k], err_a[k]);
            end
        end
        #2 rst = 1'b0;
        model_reset();
        send(0, 2'b10, 8'h10);
        send(0, 2'b11, 8'h00);
        tests++;
        if (tx_a[0] !== 1'b1 || dout_a[0] !== m_mem[0][16]) begin
            fails++;
            $display("FAIL mem_kept_after_reset tx=%b dout=%h required 1/%h", tx_a[0], dout_a[0], m_mem[0][16]);
        end
    endtask

    task automatic test_seq_err();
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        send(0, 2'b11, 8'h00);
        tests++;
        if (err_a[0] !== 1'b1 || tx_a[0] !== 1'b0 || dout_a[0] !== 8'h00) begin
            fails++;
            $display("FAIL seq_err err=%b tx=%b dout=%h required 1/0/00", err_a[0], tx_a[0], dout_a[0]);
        end
        idle(1);
        tests++;
        if (err_a[0] !== 1'b0) begin
            fails++;
            $display("FAIL seq_err_pulse err=%b required 0", err_a[0]);
        end
        send(0, 2'b10, 8'h05);
        send(0, 2'b11, 8'h00);
        tests++;
        if (tx_a[0] !== 1'b1 || err_a[0] !== 1'b0 || dout_a[0] !== m_mem[0][5]) begin
            fails++;
            $display("FAIL seq_err_recover tx=%b err=%b dout=%h required 1/0/%h",
                     tx_a[0], err_a[0], dout_a[0], m_mem[0][5]);
        end
    endtask

    task automatic test_burst();
        bit [9:0]   cmds [8] = '{10'h010, 10'h1AA, 10'h1BB, 10'h1CC, 10'h210, 10'h300, 10'h300, 10'h300};
        logic [7:0] got [$];
        for (int i = 0; i < 8; i++) begin
            send(0, cmds[i][9:8], cmds[i][7:0]);
            if (tx_a[0] === 1'b1) got.push_back(dout_a[0]);
            tests++;
            if (tx_a[0] !== e_tx[0] || err_a[0] !== 1'b0 || dout_a[0] !== m_dout[0]) begin
                fails++;
                $display("FAIL burst step=%0d tx=%b err=%b dout=%h required %b/0/%h",
                         i, tx_a[0], err_a[0], dout_a[0], e_tx[0], m_dout[0]);
            end
        end
        tests++;
        if (got.size() != 3 || got[0] !== 8'hAA || got[1] !== 8'hBB || got[2] !== 8'hCC) begin
            fails++;
            $display("FAIL burst_data got %0d words required AA BB CC", got.size());
        end
    endtask

    task automatic test_wrap();
        bit [9:0]   cmds [6] = '{10'h0FF, 10'h111, 10'h122, 10'h2FF, 10'h300, 10'h300};
        logic [7:0] got [$];
        for (int i = 0; i < 6; i++) begin
            send(0, cmds[i][9:8], cmds[i][7:0]);
            if (tx_a[0] === 1'b1) got.push_back(dout_a[0]);
            tests++;
            if (tx_a[0] !== e_tx[0] || err_a[0] !== e_err[0] || dout_a[0] !== m_dout[0]) begin
                fails++;
                $display("FAIL wrap step=%0d tx=%b err=%b dout=%h required %b/%b/%h",
                         i, tx_a[0], err_a[0], dout_a[0], e_tx[0], e_err[0], m_dout[0]);
            end
        end
        tests++;
        if (got.size() != 2 || got[0] !== 8'h11 || got[1] !== 8'h22) begin
            fails++;
            $display("FAIL wrap_data got %0d words required 11 22", got.size());
        end
    endtask

    task automatic test_depth200();
        bit [9:0]   cmds [11] = '{10'h0C8, 10'h15A, 10'h15B, 10'h2C8, 10'h300,
                                  10'h0C7, 10'h101, 10'h102, 10'h2C7, 10'h300, 10'h300};
        bit         req_err [11] = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        logic [7:0] got [$];
        for (int i = 0; i < 11; i++) begin
            send(1, cmds[i][9:8], cmds[i][7:0]);
            if (tx_a[1] === 1'b1) got.push_back(dout_a[1]);
            tests++;
            if (err_a[1] !== req_err[i] || tx_a[1] !== e_tx[1] || dout_a[1] !== m_dout[1]) begin
                fails++;
                $display("FAIL depth200 step=%0d err=%b tx=%b dout=%h required %b/%b/%h",
                         i, err_a[1], tx_a[1], dout_a[1], req_err[i], e_tx[1], m_dout[1]);
            end
        end
        tests++;
        if (got.size() != 2 || got[0] !== 8'h01 || got[1] !== 8'h02) begin
            fails++;
            $display("FAIL depth200_wrap got %0d words required 01 02", got.size());
        end
    endtask

    task automatic test_rx_gating();
        int wr_snap;
        wr_snap = m_wr[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din_a[0] = (i % 2 == 0) ? 10'h1FF : 10'h300;
            rxv_a[0] = 1'b0;
            @(posedge clk);
            #1;
            tests++;
            if (tx_a[0] !== 1'b0 || err_a[0] !== 1'b0 || dout_a[0] !== m_dout[0]) begin
                fails++;
                $display("FAIL rx_gating cycle=%0d tx=%b err=%b dout=%h required 0/0/%h",
                         i, tx_a[0], err_a[0], dout_a[0], m_dout[0]);
            end
        end
        send(0, 2'b10, 8'(wr_snap));
        send(0, 2'b11, 8'h00);
        tests++;
        if (tx_a[0] !== 1'b1 || dout_a[0] !== m_mem[0][wr_snap]) begin
            fails++;
            $display("FAIL rx_gating_mem tx=%b dout=%h required 1/%h", tx_a[0], dout_a[0], m_mem[0][wr_snap]);
        end
    endtask

    task automatic test_no_autoinc();
        bit [9:0]   cmds [6] = '{10'h003, 10'h177, 10'h188, 10'h203, 10'h300, 10'h300};
        logic [7:0] got [$];
        for (int i = 0; i < 6; i++) begin
            send(2, cmds[i][9:8], cmds[i][7:0]);
            if (tx_a[2] === 1'b1) got.push_back(dout_a[2]);
        end
        tests++;
        if (got.size() != 2 || got[0] !== 8'h88 || got[1] !== 8'h88) begin
            fails++;
            $display("FAIL no_autoinc got %0d words (%h) required 88 88",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        bit [7:0] y;
        y = 8'($urandom);
        send(0, 2'b10, 8'h41);
        send(0, 2'b00, 8'h41);
        send(0, 2'b01, y);
        send(0, 2'b11, 8'h00);
        tests++;
        if (tx_a[0] !== 1'b1 || dout_a[0] !== y) begin
            fails++;
            $display("FAIL back_to_back tx=%b dout=%h required 1/%h", tx_a[0], dout_a[0], y);
        end
    endtask

    task automatic test_random();
        bit [7:0] pay;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    idle(1);
                end else begin
                    pay = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(190, 255)) : 8'($urandom);
                    send(k, 2'($urandom), pay);
                end
                tests++;
                if (tx_a[k] !== e_tx[k] || err_a[k] !== e_err[k] || dout_a[k] !== m_dout[k] ||
                    (tx_a[k] === 1'b1 && err_a[k] === 1'b1)) begin
                    fails++;
                    $display("FAIL random k=%0d i=%0d tx=%b err=%b dout=%h required %b/%b/%h",
                             k, i, tx_a[k], err_a[k], dout_a[k], e_tx[k], e_err[k], m_dout[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            din_a[j] = '0;
            rxv_a[j] = 1'b0;
        end
        model_reset();
        #12;
        test_reset();
        rst = 1'b0;
        test_fill();
        test_async_reset();
        test_seq_err();
        test_burst();
        test_wrap();
        test_depth200();
        test_rx_gating();
        test_no_autoinc();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised single-port RAM for the SPI slave datapath; successor to the fixed 256x8 SPI RAM.
- Accepts the same 2-bit-opcode command word from the SPI slave: write address, write data, read address, read data.
- Adds configurable width and depth.
- Adds optional address auto-increment, so one address command can be followed by burst reads or writes.
- Adds out-of-range and read-sequence error detection on the `err` output.

Parameters:
- WIDTH, 8, address and data payload width in bits; the command word is WIDTH+2 bits.
- MEM_DEPTH, 256, number of words; must satisfy 2 <= MEM_DEPTH <= 2**WIDTH and need not be a power of two.
- AUTO_INC, 1, 1 = address register post-increments after each successful data write/read; 0 = address holds.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- din  in  WIDTH+2  command word; din[WIDTH+1:WIDTH] = opcode, din[WIDTH-1:0] = payload.
- rx_valid  in  1  din valid this cycle; exactly one command is consumed per cycle while high.
- dout  out  WIDTH  read data; holds its value until the next successful read.
- tx_valid  out  1  one-cycle pulse, dout updated this cycle.
- err  out  1  one-cycle pulse, command rejected.

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-high (`rst`).
- Reset state, asserted asynchronously:
  - dout=0, tx_valid=0, err=0.
  - wr_addr=0, rd_addr=0, rd_addr_loaded=0.
  - Memory contents are NOT cleared.
- Reset mid-operation clears all outputs immediately, including a tx_valid pulse in flight.
- All commands are evaluated at the rising edge of clk when rx_valid=1.
- Opcode 00, write address:
  - wr_addr <= payload.
  - Accepted even when payload >= MEM_DEPTH; the range check happens at use.
- Opcode 01, write data:
  - If wr_addr < MEM_DEPTH: mem[wr_addr] <= payload.
  - With AUTO_INC=1, wr_addr <= (wr_addr == MEM_DEPTH-1) ? 0 : wr_addr+1.
  - Otherwise: no write, no increment, err=1 for one cycle.
- Opcode 10, read address:
  - rd_addr <= payload; rd_addr_loaded <= 1.
- Opcode 11, read data:
  - If rd_addr_loaded && rd_addr < MEM_DEPTH: dout <= mem[rd_addr] and tx_valid=1, both visible the cycle after the command edge (1-cycle latency).
  - With AUTO_INC=1, rd_addr increments with the same wrap rule as wr_addr.
  - Otherwise: dout holds, tx_valid=0, err=1.
  - The payload is ignored.
- rx_valid=0: no register or memory changes; tx_valid=0 and err=0 on the following cycle.
- tx_valid and err are never high together and are never held high for more than one cycle per command.
- Back-to-back commands:
  - A read of an address written on the previous cycle returns the new data; there is no bypass hazard because there is one command per cycle.
  - Consecutive opcode-11 commands give back-to-back tx_valid pulses with successive words.
- wr_addr and rd_addr are independent registers; write bursts never disturb the read pointer and vice versa.
- Address arithmetic is WIDTH bits, unsigned; the wrap is to 0 at MEM_DEPTH-1, never at 2**WIDTH when MEM_DEPTH < 2**WIDTH.

Test Plan:
1. Async reset (WIDTH=8, MEM_DEPTH=256, AUTO_INC=1 unless stated):
   - Assert rst for 3 ns between clock edges while tx_valid=1.
   - Required: dout=0x00 and tx_valid=0 before the next edge.
   - Earlier-written mem[0x10] still reads back its value after reset.
2. Write/read burst:
   - Send 00_10, 01_AA, 01_BB, 01_CC, then 10_10, 11_00, 11_00, 11_00.
   - Required: three consecutive tx_valid pulses with dout = 0xAA, 0xBB, 0xCC; err never asserted.
3. Wrap-around:
   - Send 00_FF, 01_11, 01_22, then 10_FF, 11, 11.
   - Required: dout 0x11 then 0x22, i.e. mem[0xFF]=0x11 and mem[0x00]=0x22.
4. Read sequence error:
   - After reset, send 11_00.
   - Required: err=1 for one cycle, tx_valid=0, dout=0x00.
   - Then send 10_05, 11_00; required: tx_valid=1 with dout=mem[5].
5. Non-power-of-two depth (MEM_DEPTH=200):
   - Send 00_C8 then 01_5A. Required: err pulse, no memory change, wr_addr stays 0xC8.
   - Then send 00_C7, 01_01, 01_02. Required: mem[199]=0x01 and mem[0]=0x02.
6. rx_valid gating and AUTO_INC=0:
   - With rx_valid=0, drive 01_FF and 11_00 for 5 cycles. Required: no tx_valid, no err, memory unchanged.
   - With AUTO_INC=0, send 00_03, 01_77, 01_88, 10_03, 11, 11. Required: dout 0x88 on both pulses.
